// File: rtl/aexm_pkg.sv
// aexm_pkg: shared constants for the aexm multiply/divide unit.
// Holds the rMDUOP opcode encodings, the MDU state encoding and the default width.
package aexm_pkg;

    localparam int unsigned AEXM_DW = 32;

    // rMDUOP encodings (6 and 7 are reserved)
    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHU  = 3'd2;
    localparam logic [2:0] MDU_MULHSU = 3'd3;
    localparam logic [2:0] MDU_IDIV   = 3'd4;
    localparam logic [2:0] MDU_IDIVU  = 3'd5;

    // MDU controller states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_DSET = 3'd2;
    localparam logic [2:0] ST_DITR = 3'd3;
    localparam logic [2:0] ST_DFIX = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

endpackage

// File: rtl/aexm_mdu_mulpipe.sv
// aexm_mdu_mulpipe: stall-free multiplier pipeline.
// Takes (DW+1)-bit sign/zero-extended operands and shifts the 2*DW-bit product
// through MUL_STAGES registers; the output is the last stage.
module aexm_mdu_mulpipe #(
    parameter int unsigned DW         = 32,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW:0]       a,
    input  logic [DW:0]       b,
    output logic [2*DW-1:0]   p
);

    logic signed [2*DW-1:0] a_x;
    logic signed [2*DW-1:0] b_x;
    logic [2*DW-1:0]        pipe_d [MUL_STAGES];
    logic [2*DW-1:0]        pipe_q [MUL_STAGES];

    // Form the product into stage 0 and shift the older stages along.
    always_comb begin
        a_x = {{(DW-1){a[DW]}}, a};
        b_x = {{(DW-1){b[DW]}}, b};
        pipe_d[0] = a_x * b_x;
        for (int unsigned i = 1; i < MUL_STAGES; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipeline registers, flushed by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MUL_STAGES; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign p = pipe_q[MUL_STAGES-1];

endmodule

// File: rtl/aexm_mdu.sv
// aexm_mdu: multi-cycle multiply/divide unit beside the aexm execute stage.
// Pipelined multiplier (low/high words) plus an optional restoring radix-2
// divider, enabled by defining AEXM_MDU_DIV_EN. Without it, IDIV/IDIVU act as
// reserved ops (result 0, done one cycle after accept).
module aexm_mdu
    import aexm_pkg::*;
#(
    parameter int unsigned DW         = AEXM_DW,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          x_en,
    input  logic          xGO,
    input  logic          xSKIP,
    input  logic [2:0]    rMDUOP,
    input  logic [DW-1:0] rOPA,
    input  logic [DW-1:0] rOPB,
    output logic          rMDU_BUSY,
    output logic          rMDU_DONE,
    output logic [DW-1:0] rMDU_RES,
    output logic          rMDU_DZ
);

    localparam int unsigned CW = $clog2(DW);

    logic [2:0]       state_d, state_q;
    logic [2:0]       op_d, op_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic [DW-1:0]    res_d, res_q;
    logic             dz_d, dz_q;
    logic             accept;
    logic             a_sgn, b_sgn;
    logic [DW:0]      mul_a, mul_b;
    logic [2*DW-1:0]  prod;
`ifdef AEXM_MDU_DIV_EN
    // a_q holds the divisor magnitude, b_q the dividend shifting into the quotient
    logic [DW-1:0]    a_d, a_q;
    logic [DW-1:0]    b_d, b_q;
    logic [DW-1:0]    rem_d, rem_q;
    logic             neg_d, neg_q;
    logic             a_neg, b_neg;
    logic [DW:0]      rem_sh, diff;
`endif

    // The pipe is fed from the live operands so the accept-cycle product
    // reaches the last stage exactly when the MUL count expires.
    always_comb begin
        a_sgn = (rMDUOP == MDU_MULH) || (rMDUOP == MDU_MULHSU);
        b_sgn = (rMDUOP == MDU_MULH);
        mul_a = {a_sgn & rOPA[DW-1], rOPA};
        mul_b = {b_sgn & rOPB[DW-1], rOPB};
    end

    aexm_mdu_mulpipe #(
        .DW         (DW),
        .MUL_STAGES (MUL_STAGES)
    ) u_mulpipe (
        .clk (gclk),
        .rst (grst),
        .a   (mul_a),
        .b   (mul_b),
        .p   (prod)
    );

    // Controller: state sequencing, divider datapath and result capture.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dz_d    = dz_q;
        accept  = xGO & ~xSKIP & x_en & ((state_q == ST_IDLE) || (state_q == ST_DONE));
`ifdef AEXM_MDU_DIV_EN
        a_d    = a_q;
        b_d    = b_q;
        rem_d  = rem_q;
        neg_d  = neg_q;
        a_neg  = (op_q == MDU_IDIV) & a_q[DW-1];
        b_neg  = (op_q == MDU_IDIV) & b_q[DW-1];
        rem_sh = {rem_q, b_q[DW-1]};
        diff   = rem_sh - {1'b0, a_q};
`endif
        case (state_q)
            ST_MUL: begin
                if (cnt_q == '0) begin
                    res_d   = (op_q == MDU_MUL) ? prod[DW-1:0] : prod[2*DW-1:DW];
                    dz_d    = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef AEXM_MDU_DIV_EN
            ST_DSET: begin
                if (a_q == '0) begin
                    res_d   = '0;
                    dz_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    a_d     = a_neg ? -a_q : a_q;
                    b_d     = b_neg ? -b_q : b_q;
                    neg_d   = a_neg ^ b_neg;
                    rem_d   = '0;
                    cnt_d   = CW'(DW - 1);
                    state_d = ST_DITR;
                end
            end
            ST_DITR: begin
                if (!diff[DW]) begin
                    rem_d = diff[DW-1:0];
                    b_d   = {b_q[DW-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[DW-1:0];
                    b_d   = {b_q[DW-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = ST_DFIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DFIX: begin
                res_d   = neg_q ? -b_q : b_q;
                dz_d    = 1'b0;
                state_d = ST_DONE;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // An accept (only possible in IDLE/DONE) overrides the default next state.
        if (accept) begin
            op_d = rMDUOP;
`ifdef AEXM_MDU_DIV_EN
            a_d  = rOPA;
            b_d  = rOPB;
`endif
            case (rMDUOP)
                MDU_MUL, MDU_MULH, MDU_MULHU, MDU_MULHSU: begin
                    cnt_d   = CW'(MUL_STAGES - 1);
                    state_d = ST_MUL;
                end
`ifdef AEXM_MDU_DIV_EN
                MDU_IDIV, MDU_IDIVU: state_d = ST_DSET;
`endif
                default: begin
                    res_d   = '0;
                    dz_d    = 1'b0;
                    state_d = ST_DONE;
                end
            endcase
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
`ifdef AEXM_MDU_DIV_EN
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
`ifdef AEXM_MDU_DIV_EN
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
`endif
        end
    end

    assign rMDU_BUSY = (state_q == ST_MUL) || (state_q == ST_DSET) ||
                       (state_q == ST_DITR) || (state_q == ST_DFIX);
    assign rMDU_DONE = (state_q == ST_DONE);
    assign rMDU_RES  = res_q;
    assign rMDU_DZ   = dz_q;

endmodule
